// File: rtl/lcd_pkg.sv
// Shared timing helpers, state encoding and init-table types for the LCD sequencer.
package lcd_pkg;

    localparam int unsigned DEF_FREQ = 50000000;
    localparam int unsigned INIT_LEN = 12;

    function automatic longint unsigned us_to_cycles(input longint unsigned us,
                                                     input longint unsigned freq);
        return (us * freq) / 64'd1000000;
    endfunction

    // Reference delays at the default clock; per-instance values come from us_to_cycles(.., FREQ).
    localparam logic [20:0] T_1US     = 21'(us_to_cycles(1, DEF_FREQ));
    localparam logic [20:0] T_40US    = 21'(us_to_cycles(40, DEF_FREQ));
    localparam logic [20:0] T_100US   = 21'(us_to_cycles(100, DEF_FREQ));
    localparam logic [20:0] T_4100US  = 21'(us_to_cycles(4100, DEF_FREQ));
    localparam logic [20:0] T_1640US  = 21'(us_to_cycles(1640, DEF_FREQ));
    localparam logic [20:0] T_POWERON = 21'(us_to_cycles(15000, DEF_FREQ));

    typedef enum logic [3:0] {
        PWR_WAIT,
        INIT_ISSUE,
        INIT_WAIT,
        INIT_GAP,
        IDLE,
        HI_ISSUE,
        HI_WAIT,
        GAP,
        LO_ISSUE,
        LO_WAIT,
        DONE_GAP
    } seq_state_t;

    typedef struct packed {
        logic [3:0]  nibble;
        logic [20:0] delay;
    } init_entry_t;

endpackage

// File: rtl/lcd_init_rom.sv
// HD44780 4-bit power-on init table: index -> {nibble, post-nibble delay in cycles}.
module lcd_init_rom import lcd_pkg::*; #(
    parameter int unsigned FREQ = DEF_FREQ
) (
    input  logic [3:0]  idx,
    output init_entry_t entry
);

    localparam logic [20:0] D1    = 21'(us_to_cycles(1, FREQ));
    localparam logic [20:0] D40   = 21'(us_to_cycles(40, FREQ));
    localparam logic [20:0] D100  = 21'(us_to_cycles(100, FREQ));
    localparam logic [20:0] D1640 = 21'(us_to_cycles(1640, FREQ));
    localparam logic [20:0] D4100 = 21'(us_to_cycles(4100, FREQ));

    always_comb begin
        entry = '0;
        case (idx)
            4'd0:    entry = '{4'h3, D4100};
            4'd1:    entry = '{4'h3, D100};
            4'd2:    entry = '{4'h3, D40};
            4'd3:    entry = '{4'h2, D40};
            4'd4:    entry = '{4'h2, D1};
            4'd5:    entry = '{4'h8, D40};
            4'd6:    entry = '{4'h0, D1};
            4'd7:    entry = '{4'hC, D40};
            4'd8:    entry = '{4'h0, D1};
            4'd9:    entry = '{4'h1, D1640};
            4'd10:   entry = '{4'h0, D1};
            4'd11:   entry = '{4'h6, D40};
            default: entry = '0;
        endcase
    end

endmodule

// File: rtl/lcd_sequencer.sv
// Plays the LCD power-on init sequence, then splits accepted bytes into two
// nibble transfers for the downstream transfer stage.
module lcd_sequencer import lcd_pkg::*; #(
    parameter int unsigned FREQ       = 50000000,
    parameter int unsigned POWERON_US = 15000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [7:0]  wr_data,
    input  logic        wr_rs,
    output logic        init_done,
    output logic        sendCommand,
    output logic [3:0]  command,
    output logic        command_rs,
    output logic [20:0] commandDelay,
    input  logic        commandDone
);

    localparam longint unsigned PWR_CYC = us_to_cycles(POWERON_US, FREQ);
    localparam longint unsigned MAX_CYC = us_to_cycles(4100, FREQ);

    if (PWR_CYC >= 64'd2097152 || MAX_CYC >= 64'd2097152) begin : g_range_chk
        $error("lcd_sequencer: FREQ-derived delay does not fit in 21 bits");
    end

    localparam logic [20:0] T_PWR   = 21'(PWR_CYC);
    localparam logic [20:0] T_U1    = 21'(us_to_cycles(1, FREQ));
    localparam logic [20:0] T_U40   = 21'(us_to_cycles(40, FREQ));
    localparam logic [20:0] T_U1640 = 21'(us_to_cycles(1640, FREQ));

    seq_state_t  state;
    logic [20:0] counter;
    logic [3:0]  init_idx;
    init_entry_t rom_entry;
    logic [7:0]  byte_q;
    logic        rs_q;
    logic [20:0] lo_delay;

    lcd_init_rom #(.FREQ(FREQ)) u_rom (
        .idx   (init_idx),
        .entry (rom_entry)
    );

    // Latched byte is pure data: no reset, only captured on the handshake.
    always_ff @(posedge CLK) begin
        if (state == IDLE && wr_valid && wr_ready) begin
            byte_q <= wr_data;
            rs_q   <= wr_rs;
        end
    end

    // Clear and return-home instructions need the long busy delay.
    always_comb begin
        lo_delay = T_U40;
        if (!rs_q && (byte_q == 8'h01 || byte_q == 8'h02 || byte_q == 8'h03))
            lo_delay = T_U1640;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state        <= PWR_WAIT;
            counter      <= '0;
            init_idx     <= '0;
            wr_ready     <= 1'b0;
            init_done    <= 1'b0;
            sendCommand  <= 1'b0;
            command      <= '0;
            command_rs   <= 1'b0;
            commandDelay <= '0;
        end else begin
            sendCommand <= 1'b0;
            case (state)
                PWR_WAIT: begin
                    if (counter + 21'd1 >= T_PWR) begin
                        state        <= INIT_ISSUE;
                        sendCommand  <= 1'b1;
                        command      <= rom_entry.nibble;
                        command_rs   <= 1'b0;
                        commandDelay <= rom_entry.delay;
                    end else begin
                        counter <= counter + 21'd1;
                    end
                end
                INIT_ISSUE: state <= INIT_WAIT;
                INIT_WAIT: begin
                    if (commandDone) begin
                        init_idx <= init_idx + 4'd1;
                        state    <= INIT_GAP;
                    end
                end
                // The transfer stage ignores sendCommand in the cycle after commandDone.
                INIT_GAP: begin
                    if (init_idx == 4'(INIT_LEN)) begin
                        init_done <= 1'b1;
                        wr_ready  <= 1'b1;
                        state     <= IDLE;
                    end else begin
                        state        <= INIT_ISSUE;
                        sendCommand  <= 1'b1;
                        command      <= rom_entry.nibble;
                        command_rs   <= 1'b0;
                        commandDelay <= rom_entry.delay;
                    end
                end
                IDLE: begin
                    if (wr_valid && wr_ready) begin
                        wr_ready     <= 1'b0;
                        state        <= HI_ISSUE;
                        sendCommand  <= 1'b1;
                        command      <= wr_data[7:4];
                        command_rs   <= wr_rs;
                        commandDelay <= T_U1;
                    end
                end
                HI_ISSUE: state <= HI_WAIT;
                HI_WAIT:  if (commandDone) state <= GAP;
                GAP: begin
                    state        <= LO_ISSUE;
                    sendCommand  <= 1'b1;
                    command      <= byte_q[3:0];
                    command_rs   <= rs_q;
                    commandDelay <= lo_delay;
                end
                LO_ISSUE: state <= LO_WAIT;
                LO_WAIT:  if (commandDone) state <= DONE_GAP;
                DONE_GAP: begin
                    wr_ready <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= PWR_WAIT;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_sequencer.sv
// Scoreboard bench for lcd_sequencer with a cycle-level transfer-stage model driving commandDone.
`timescale 1ns/1ps
module tb_lcd_sequencer;

    localparam int FREQ = 1000000;
    localparam int PWR  = 15000;
    localparam int XFER = 3;

    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        wr_valid = 1'b0;
    logic [7:0]  wr_data = 8'h00;
    logic        wr_rs = 1'b0;
    logic        commandDone = 1'b0;
    logic        wr_ready, init_done, sendCommand, command_rs;
    logic [3:0]  command;
    logic [20:0] commandDelay;

    lcd_sequencer #(.FREQ(FREQ), .POWERON_US(PWR)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .wr_valid     (wr_valid),
        .wr_ready     (wr_ready),
        .wr_data      (wr_data),
        .wr_rs        (wr_rs),
        .init_done    (init_done),
        .sendCommand  (sendCommand),
        .command      (command),
        .command_rs   (command_rs),
        .commandDelay (commandDelay),
        .commandDone  (commandDone)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int nib;
        int rs;
        int dly;
        int first_cyc;
        bit gap2;
        bit last;
    } exp_t;

    exp_t expq[$];
    int   total = 0;
    int   bad = 0;
    int   cyc;
    int   init_nib[12] = '{3, 3, 3, 2, 2, 8, 0, 12, 0, 1, 0, 6};
    int   init_dly[12] = '{4100, 100, 40, 40, 1, 40, 1, 40, 1, 1640, 1, 40};

    int   mst = 0;
    int   mrem = 0;
    int   done_cyc = -100;
    int   ready_due = -1;
    bit   cur_last = 1'b0;
    bit   prev_init_done = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic push_init();
        for (int i = 0; i < 12; i++) begin
            exp_t e;
            e.nib       = init_nib[i];
            e.rs        = 0;
            e.dly       = init_dly[i];
            e.first_cyc = (i == 0) ? PWR : -1;
            e.gap2      = (i != 0);
            e.last      = (i == 11);
            expq.push_back(e);
        end
    endtask

    task automatic push_byte(input int b, input int rs, input int acc_cyc);
        exp_t e;
        e.nib       = b / 16;
        e.rs        = rs;
        e.dly       = 1;
        e.first_cyc = acc_cyc + 1;
        e.gap2      = 1'b0;
        e.last      = 1'b0;
        expq.push_back(e);
        e.nib       = b % 16;
        e.dly       = (rs == 0 && b >= 1 && b <= 3) ? 1640 : 40;
        e.first_cyc = -1;
        e.gap2      = 1'b1;
        e.last      = 1'b1;
        expq.push_back(e);
    endtask

    always @(posedge CLK or posedge RST) begin
        if (RST) cyc <= 0;
        else     cyc <= cyc + 1;
    end

    // Transfer-stage model: busy for delay+XFER cycles, one-cycle done pulse,
    // then one done-state cycle in which a new start would be dropped.
    always @(negedge CLK) begin
        if (RST) begin
            mst         = 0;
            commandDone = 1'b0;
            ready_due   = -1;
        end else begin
            if (sendCommand) check("stage_idle_on_send", mst, 0);
            case (mst)
                0: if (sendCommand) begin
                    mst  = 1;
                    mrem = int'(commandDelay) + XFER;
                end
                1: begin
                    mrem--;
                    if (mrem == 0) begin
                        commandDone = 1'b1;
                        done_cyc    = cyc;
                        if (cur_last) ready_due = cyc + 2;
                        mst = 2;
                    end
                end
                default: begin
                    commandDone = 1'b0;
                    mst = 0;
                end
            endcase
        end
    end

    // Monitor: pops the scoreboard on every start pulse and checks handshake timing.
    always @(negedge CLK) begin
        exp_t e;
        if (RST) begin
            prev_init_done = 1'b0;
        end else begin
            if (sendCommand) begin
                if (expq.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_send: command=%0h rs=%0d with nothing expected (cyc %0d)",
                             command, command_rs, cyc);
                end else begin
                    e = expq.pop_front();
                    check("command", int'(command), e.nib);
                    check("command_rs", int'(command_rs), e.rs);
                    check("commandDelay", int'(commandDelay), e.dly);
                    if (e.first_cyc >= 0) check("issue_cycle", cyc, e.first_cyc);
                    if (e.gap2) check("gap_after_done", cyc - done_cyc, 2);
                    cur_last = e.last;
                end
            end
            if (ready_due == cyc) begin
                check("wr_ready_after_done", int'(wr_ready), 1);
                check("init_done_after_done", int'(init_done), 1);
            end
            if (ready_due == cyc + 1) check("wr_ready_low_in_gap", int'(wr_ready), 0);
            if (wr_ready) begin
                check("ready_implies_init_done", int'(init_done), 1);
                check("ready_with_stage_idle", mst, 0);
            end
            if (init_done && !prev_init_done) check("init_done_rise_cycle", cyc, ready_due);
            if (prev_init_done) check("init_done_sticky", int'(init_done), 1);
            prev_init_done = init_done;
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wr_ready"}, int'(wr_ready), 0);
        check({tag, "_init_done"}, int'(init_done), 0);
        check({tag, "_sendCommand"}, int'(sendCommand), 0);
        check({tag, "_command"}, int'(command), 0);
        check({tag, "_command_rs"}, int'(command_rs), 0);
        check({tag, "_commandDelay"}, int'(commandDelay), 0);
    endtask

    // Called at a negedge; returns at a later negedge.
    task automatic write_byte(input int b, input int rs, input bit hold_next);
        int wait_n = 0;
        wr_valid = 1'b1;
        wr_data  = 8'(b);
        wr_rs    = rs[0];
        while (!wr_ready && wait_n < 40000) begin
            @(negedge CLK);
            wait_n++;
        end
        if (!wr_ready) begin
            total++;
            bad++;
            $display("FAIL write_timeout: byte %02h not accepted within %0d cycles", b, wait_n);
        end else begin
            push_byte(b, rs, cyc);
        end
        @(negedge CLK);
        if (!hold_next) wr_valid = 1'b0;
    endtask

    task automatic wait_ready();
        int n = 0;
        while (!wr_ready && n < 10000) begin
            @(negedge CLK);
            n++;
        end
        check("drain_ready", int'(wr_ready), 1);
    endtask

    initial begin
        int b;
        int rs;
        RST = 1'b1;
        @(negedge CLK);
        check_reset_outputs("reset");
        @(negedge CLK);
        #1 RST = 1'b0;
        push_init();
        @(negedge CLK);

        // Request held during init: must wait for init_done, never interleave.
        write_byte(8'h41, 1, 1'b0);
        write_byte(8'h01, 0, 1'b0);
        write_byte(8'h01, 1, 1'b0);
        write_byte(8'h04, 0, 1'b0);
        write_byte(8'h00, 0, 1'b0);
        write_byte(8'h03, 0, 1'b0);
        write_byte(8'h48, 1, 1'b1);
        write_byte(8'h49, 1, 1'b0);

        for (int i = 0; i < 12; i++) begin
            b  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 3)) : int'($urandom_range(0, 255));
            rs = int'($urandom_range(0, 1));
            write_byte(b, rs, $urandom_range(0, 1) == 1);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        wr_valid = 1'b0;
        wait_ready();

        // Abort a byte during its high-nibble wait.
        write_byte(8'h5A, 1, 1'b0);
        @(negedge CLK);
        #1 RST = 1'b1;
        #1 check_reset_outputs("midreset");
        expq.delete();
        repeat (3) @(negedge CLK);
        #1 RST = 1'b0;
        push_init();
        @(negedge CLK);
        write_byte(8'h42, 1, 1'b0);
        wait_ready();
        repeat (4) @(negedge CLK);
        check("queue_drained", expq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lcd_sequencer.md
Name: lcd_sequencer

Overview:
- Upstream feeder for the 4-bit LCD nibble-transfer stage (sendCommand/command/command_rs/commandDelay -> commandDone).
- After reset it plays the HD44780 4-bit power-on init sequence.
- It then accepts byte writes (command or data) over a valid/ready handshake and splits each byte into two nibble transfers, each with the correct post-nibble delay.
- init_done tells the text/display logic above that the panel is usable.

Parameters:
- FREQ, 50000000, clock frequency in Hz. All delays are derived from it as cycles = us * FREQ / 1000000.
- POWERON_US, 15000, wait after reset before the first init nibble.

Ports:
- CLK  input  1  system clock
- RST  input  1  asynchronous, active-high reset
- wr_valid  input  1  byte write request
- wr_ready  output  1  sequencer can accept a byte
- wr_data  input  8  byte to send
- wr_rs  input  1  0 = instruction, 1 = data register
- init_done  output  1  init sequence complete; sticky until RST
- sendCommand  output  1  one-cycle start pulse to the transfer stage
- command  output  4  nibble to transfer
- command_rs  output  1  RS for the nibble
- commandDelay  output  21  busy delay after the nibble, in cycles
- commandDone  input  1  one-cycle completion pulse from the transfer stage

Behaviour:
- Reset values: wr_ready=0, init_done=0, sendCommand=0, command=0, command_rs=0, commandDelay=0. State=PWR_WAIT, counter=0, init index=0.
- RST is asynchronous at any time, including mid-transfer. It returns to PWR_WAIT and the whole init sequence reruns. Any latched byte is discarded.
- Internal 21-bit counter; every delay constant fits in 21 bits (assert FREQ-derived values < 2^21).
- States: PWR_WAIT, INIT_ISSUE, INIT_WAIT, INIT_GAP, IDLE, HI_ISSUE, HI_WAIT, GAP, LO_ISSUE, LO_WAIT, DONE_GAP.
- PWR_WAIT: count to POWERON_US cycles, then go to INIT_ISSUE.
- Init table: 12 nibble entries, all rs=0:
  - 3/4100us, 3/100us, 3/40us, 2/40us
  - 2/1us, 8/40us (0x28 function set)
  - 0/1us, C/40us (0x0C display on)
  - 0/1us, 1/1640us (0x01 clear)
  - 0/1us, 6/40us (0x06 entry mode)
- INIT_ISSUE: sendCommand=1 for exactly one cycle. command, command_rs and commandDelay hold the current entry from this cycle until commandDone.
- INIT_WAIT: wait for commandDone, then increment the index and go to INIT_GAP.
- INIT_GAP: one idle cycle. This is mandatory: the transfer stage spends one cycle in its done state after commandDone and ignores sendCommand there. If the index is 12, set init_done=1 and go to IDLE; otherwise go to INIT_ISSUE.
- IDLE: wr_ready=1 (only in IDLE with init_done=1).
  - On wr_valid & wr_ready, latch wr_data and wr_rs; wr_ready is 0 from the next cycle.
  - Next state is HI_ISSUE.
- HI_ISSUE: command=data[7:4], command_rs=rs, commandDelay=1us, sendCommand pulse. Then HI_WAIT until commandDone, then GAP (1 cycle), then LO_ISSUE.
- LO_ISSUE: command=data[3:0], pulse sendCommand.
  - commandDelay=1640us if rs=0 and data in {0x01, 0x02, 0x03} (clear/home); otherwise 40us.
  - Then LO_WAIT until commandDone, then DONE_GAP (1 cycle), then IDLE.
- Latency: an accepted byte gets its first sendCommand 1 cycle after acceptance. wr_ready returns 2 cycles after the second commandDone.
- commandDone outside a *_WAIT state is ignored. At most one transfer is outstanding at any time.
- Outputs are registered or decoded from registered state only; no combinational path from wr_valid to sendCommand.
- wr_valid held high in IDLE before init_done is not accepted and not lost; it is accepted once IDLE and init_done are both true.

Decomposition:
- Package lcd_pkg holds:
  - us_to_cycles function
  - delay constants: T_1US, T_40US, T_100US, T_4100US, T_1640US, T_POWERON
  - sequencer state enum
  - init entry struct {nibble[3:0], delay[20:0]}
  - INIT_LEN = 12
- One natural sub-module: lcd_init_rom, a combinational index -> entry lookup (parameterised by FREQ).
- The transfer stage is instantiated alongside this block at top level, not inside it.

Test Plan (bench FREQ=1000000, so 1us = 1 cycle; the real lcd_transfer, or a model with identical done/idle timing, drives commandDone):
- Release RST -> no sendCommand for 15000 cycles. Then 12 pulses with command = 3,3,3,2,2,8,0,C,0,1,0,6 and commandDelay = 4100,100,40,40,1,40,1,40,1,1640,1,40. init_done rises 1 cycle after the 12th commandDone + gap.
- After init, write 0x41 with rs=1 -> nibbles 4 (delay 1) and 1 (delay 40), command_rs=1 on both. wr_ready low during the write, high again 2 cycles after the second commandDone.
- Write 0x01 with rs=0 -> nibbles 0/1 and 1/1640. Write 0x01 with rs=1 -> low delay 40.
- wr_valid held continuously with bytes 0x48, 0x49 -> exactly 4 transfers in order 4,8,4,9. Each sendCommand is ≥2 cycles after the previous commandDone, and none is dropped by the transfer stage.
- Assert wr_valid during init -> wr_ready stays 0 and no byte nibbles are interleaved with init entries.
- Assert RST during HI_WAIT of a write -> all outputs return to reset values immediately. After release, the full 15000-cycle wait and init sequence repeat, and the aborted byte is never sent.
